// File: rtl/con_mon_if.sv
// ---------------------------------------------------------------------------
// con_mon_if : bundle between the 3-bit up/down counter, the counter monitor
//              and the seven-segment display pins.
//
//   x        counter direction (1 = up, 0 = down)
//   s2..s0   counter value, s2 is the MSB
//   seg      active-low segments {g,f,e,d,c,b,a}
//   laps     net lap (wrap) count, modulo 2^LAP_W
//   lap_tick one-cycle pulse per wrap
//   err      sticky illegal-transition flag
//   dir      direction sampled on the previous clock
//
// master : counter/display side (drives x and the count, observes results)
// slave  : the monitor itself
// ---------------------------------------------------------------------------
interface con_mon_if #(
  parameter int LAP_W = 4
);
  logic             x;
  logic             s2;
  logic             s1;
  logic             s0;
  logic [6:0]       seg;
  logic [LAP_W-1:0] laps;
  logic             lap_tick;
  logic             err;
  logic             dir;

  modport master (
    output x, s2, s1, s0,
    input  seg, laps, lap_tick, err, dir
  );

  modport slave (
    input  x, s2, s1, s0,
    output seg, laps, lap_tick, err, dir
  );
endinterface

// File: rtl/con_mon.sv
// ---------------------------------------------------------------------------
// con_mon : monitor for a 3-bit up/down counter.
//
// Watches every transition of cnt = {s2,s1,s0} against the previously sampled
// value and the direction from one cycle earlier (the counter steps on that
// old direction). Legal steps update the display digit and, on 7->0 / 0->7
// wraps, the lap counter. Anything else latches a sticky error and parks the
// monitor in FAULT, showing "E" until res.
//
// Ports:
//   clk  in   rising-edge clock
//   res  in   synchronous active-high reset (priority over everything)
//   bus  slave modport of con_mon_if (x, s2..s0 in; seg, laps, lap_tick,
//        err, dir out -- all outputs registered)
//
// Parameters:
//   LAP_W     width of the lap counter
//   BLINK_DIV log2 of the FAULT blink half-period (blink build only)
//
// Build option:
//   CON_MON_BLINK_EN  when defined, the FAULT display alternates between "E"
//                     and blank every 2^BLINK_DIV cycles; otherwise it shows
//                     a steady "E".
// ---------------------------------------------------------------------------
module con_mon #(
  parameter int LAP_W     = 4,
  parameter int BLINK_DIV = 8
) (
  input  logic        clk,
  input  logic        res,
  con_mon_if.slave    bus
);

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_E     = 7'h06;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    TRACK = 2'd1,
    FAULT = 2'd2
  } state_t;

  // Active-low gfedcba pattern for one counter value.
  function automatic logic [6:0] digit(input logic [2:0] v);
    logic [6:0] s;
    case (v)
      3'd0:    s = 7'h40;
      3'd1:    s = 7'h79;
      3'd2:    s = 7'h24;
      3'd3:    s = 7'h30;
      3'd4:    s = 7'h19;
      3'd5:    s = 7'h12;
      3'd6:    s = 7'h02;
      3'd7:    s = 7'h78;
      default: s = SEG_BLANK;
    endcase
    return s;
  endfunction

  state_t           state_q, state_d;
  logic [2:0]       prev_q, prev_d;
  logic             xd_q, xd_d;
  logic [6:0]       seg_q, seg_d;
  logic [LAP_W-1:0] laps_q, laps_d;
  logic             tick_q, tick_d;
  logic             err_q, err_d;

  logic [2:0]       cnt_s;
  logic [2:0]       delta_s;
  logic [6:0]       fault_seg_s;

  assign cnt_s   = {bus.s2, bus.s1, bus.s0};
  // Modulo-8 difference: 1 is an up step, 7 is a down step.
  assign delta_s = cnt_s - prev_q;

`ifdef CON_MON_BLINK_EN
  logic [BLINK_DIV-1:0] div_q, div_d;
  logic                 phase_q, phase_d;

  // Divider/phase next state. The divider is restarted on FAULT entry so the
  // first "E" phase lasts the full 2^BLINK_DIV cycles.
  always_comb begin
    div_d       = div_q + {{(BLINK_DIV-1){1'b0}}, 1'b1};
    phase_d     = phase_q;
    fault_seg_s = SEG_E;
    if (state_q == FAULT) begin
      phase_d     = phase_q ^ (&div_q);
      fault_seg_s = phase_d ? SEG_BLANK : SEG_E;
    end else if (state_d == FAULT) begin
      div_d       = {BLINK_DIV{1'b0}};
      phase_d     = 1'b0;
      fault_seg_s = SEG_E;
    end else begin
      phase_d     = 1'b0;
      fault_seg_s = SEG_E;
    end
  end

  // Blink divider and phase registers.
  always_ff @(posedge clk) begin
    if (res) begin
      div_q   <= {BLINK_DIV{1'b0}};
      phase_q <= 1'b0;
    end else begin
      div_q   <= div_d;
      phase_q <= phase_d;
    end
  end
`else
  assign fault_seg_s = SEG_E;
`endif

  // Next-state and output decode for the monitor FSM.
  always_comb begin
    state_d = state_q;
    prev_d  = cnt_s;
    xd_d    = bus.x;
    seg_d   = seg_q;
    laps_d  = laps_q;
    tick_d  = 1'b0;
    err_d   = err_q;

    case (state_q)
      IDLE: begin
        // First edge after reset only captures history; nothing to check.
        seg_d   = digit(cnt_s);
        state_d = TRACK;
      end

      TRACK: begin
        if (delta_s == 3'd0) begin
          seg_d = digit(cnt_s);
        end else if (xd_q && (delta_s == 3'd1)) begin
          seg_d = digit(cnt_s);
          if (cnt_s == 3'd0) begin
            laps_d = laps_q + LAP_W'(1);
            tick_d = 1'b1;
          end else begin
            laps_d = laps_q;
          end
        end else if (!xd_q && (delta_s == 3'd7)) begin
          seg_d = digit(cnt_s);
          if (cnt_s == 3'd7) begin
            laps_d = laps_q - LAP_W'(1);
            tick_d = 1'b1;
          end else begin
            laps_d = laps_q;
          end
        end else begin
          // Jump or step against the sampled direction.
          err_d   = 1'b1;
          seg_d   = SEG_E;
          state_d = FAULT;
        end
      end

      FAULT: begin
        err_d   = 1'b1;
        seg_d   = fault_seg_s;
        state_d = FAULT;
      end

      default: begin
        seg_d   = SEG_BLANK;
        state_d = IDLE;
      end
    endcase
  end

  // State and output registers; res wins over every other event.
  always_ff @(posedge clk) begin
    if (res) begin
      state_q <= IDLE;
      prev_q  <= 3'd0;
      xd_q    <= 1'b0;
      seg_q   <= SEG_BLANK;
      laps_q  <= {LAP_W{1'b0}};
      tick_q  <= 1'b0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      prev_q  <= prev_d;
      xd_q    <= xd_d;
      seg_q   <= seg_d;
      laps_q  <= laps_d;
      tick_q  <= tick_d;
      err_q   <= err_d;
    end
  end

  assign bus.seg      = seg_q;
  assign bus.laps     = laps_q;
  assign bus.lap_tick = tick_q;
  assign bus.err      = err_q;
  assign bus.dir      = xd_q;

endmodule
